mipi_pkt_parser: RTL and testbench

Synthesizable MIPI CSI-2 / DSI packet parser: a byte-serial receive stream (post lane-merge) becomes decoded headers, a payload byte stream and per-packet integrity status. It is the RTL counterpart to the team's MIPI DSI/CSI-2 monitor models. It adds behaviour the monitors lack: header ECC single-bit correction, payload CRC-16 checking, per-virtual-channel frame tracking, and a selectable protocol mode. It sits between the D-PHY lane merger and the pixel unpacker.

---
 rtl/mipi_pkt_parser_if.sv | 35 +++
 rtl/mipi_pkt_parser.sv | 226 ++++++++++++++++++++++
 tb/tb_mipi_pkt_parser.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_pkt_parser_if.sv
// Byte-stream input and decoded header/payload/status outputs of the MIPI packet parser.
interface mipi_pkt_parser_if #(
  parameter int unsigned VC_NUM = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_sop;
  logic              hdr_valid;
  logic [1:0]        hdr_vc;
  logic [5:0]        hdr_dt;
  logic [15:0]       hdr_wc;
  logic              hdr_long;
  logic              hdr_ecc_corr;
  logic              hdr_ecc_err;
  logic              hdr_len_err;
  logic              pld_valid;
  logic [7:0]        pld_data;
  logic              pld_last;
  logic              crc_valid;
  logic              crc_err;
  logic              err_sync;
  logic [VC_NUM-1:0] frame_active;

  modport master (
    output in_valid, in_data, in_sop,
    input  hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_long, hdr_ecc_corr, hdr_ecc_err, hdr_len_err,
    input  pld_valid, pld_data, pld_last, crc_valid, crc_err, err_sync, frame_active
  );

  modport slave (
    input  in_valid, in_data, in_sop,
    output hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_long, hdr_ecc_corr, hdr_ecc_err, hdr_len_err,
    output pld_valid, pld_data, pld_last, crc_valid, crc_err, err_sync, frame_active
  );
endinterface

// File: rtl/mipi_pkt_parser.sv
// CSI-2 / DSI packet parser: header ECC correction, payload CRC-16 check and
// per-virtual-channel frame tracking on a merged byte stream.
module mipi_pkt_parser #(
  parameter bit          MODE   = 1'b0,
  parameter int unsigned VC_NUM = 4,
  parameter int unsigned MAX_WC = 4096
) (
  input logic              clk,
  input logic              resetn,
  mipi_pkt_parser_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StHdr, StPld, StCrc, StDiscard} state_e;

  typedef struct packed {
    logic        hdr_valid;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic        hdr_ecc_corr;
    logic        hdr_ecc_err;
    logic        hdr_len_err;
    logic        pld_valid;
    logic [7:0]  pld_data;
    logic        pld_last;
    logic        crc_valid;
    logic        crc_err;
    logic        err_sync;
  } out_t;

  state_e            state_q, state_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [7:0]        di_q, di_d, wc_lo_q, wc_lo_d, wc_hi_q, wc_hi_d, crc_lo_q, crc_lo_d;
  logic [15:0]       wc_q, wc_d, cnt_q, cnt_d, crc_q, crc_d;
  logic              crc_ph_q, crc_ph_d;
  out_t              out_q, out_d;
  logic [VC_NUM-1:0] frame_q, frame_d;

  logic [23:0] hdr_raw, hdr_fix;
  logic [5:0]  syn;
  logic        ecc_corr, ecc_err, is_long, len_err;

  function automatic logic [5:0] ecc_calc(logic [23:0] d);
    ecc_calc = {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  function automatic logic is_short_dt(logic [5:0] dt);
    if (!MODE) return dt <= 6'h0F;
    case (dt)
      6'h01, 6'h11, 6'h21, 6'h31, 6'h08, 6'h22, 6'h32, 6'h02, 6'h12,
      6'h04, 6'h14, 6'h24, 6'h03, 6'h13, 6'h23, 6'h05, 6'h15, 6'h06: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reflected CRC-16 (0x8408), LSB first.
  function automatic logic [15:0] crc_byte(logic [15:0] c, logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Header decode, evaluated while the ECC byte is on in_data.
  always_comb begin
    hdr_raw  = {wc_hi_q, wc_lo_q, di_q};
    hdr_fix  = hdr_raw;
    ecc_corr = 1'b0;
    ecc_err  = 1'b0;
    syn      = ecc_calc(hdr_raw) ^ bus.in_data[5:0];
    if (syn != 6'd0) begin
      if ((syn & (syn - 6'd1)) == 6'd0) begin
        ecc_corr = 1'b1;
      end else begin
        for (int i = 0; i < 24; i++) begin
          if (syn == ecc_calc(24'd1 << i)) begin
            hdr_fix[i] = ~hdr_raw[i];
            ecc_corr   = 1'b1;
          end
        end
        ecc_err = ~ecc_corr;
      end
    end
    is_long = ~is_short_dt(hdr_fix[5:0]);
    len_err = is_long && ({16'd0, hdr_fix[23:8]} > MAX_WC);
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    di_d     = di_q;
    wc_lo_d  = wc_lo_q;
    wc_hi_d  = wc_hi_q;
    crc_lo_d = crc_lo_q;
    wc_d     = wc_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    crc_ph_d = crc_ph_q;
    frame_d  = frame_q;
    out_d    = out_q;
    out_d.hdr_valid = 1'b0;
    out_d.pld_valid = 1'b0;
    out_d.pld_last  = 1'b0;
    out_d.crc_valid = 1'b0;
    out_d.err_sync  = 1'b0;

    if (bus.in_valid) begin
      if (bus.in_sop) begin
        out_d.err_sync = state_q inside {StHdr, StPld, StCrc};
        di_d    = bus.in_data;
        hcnt_d  = 2'd0;
        state_d = StHdr;
      end else begin
        unique case (state_q)
          StHdr: begin
            if (hcnt_q == 2'd0) begin
              wc_lo_d = bus.in_data;
              hcnt_d  = 2'd1;
            end else if (hcnt_q == 2'd1) begin
              wc_hi_d = bus.in_data;
              hcnt_d  = 2'd2;
            end else begin
              out_d.hdr_valid    = 1'b1;
              out_d.hdr_vc       = hdr_fix[7:6];
              out_d.hdr_dt       = hdr_fix[5:0];
              out_d.hdr_wc       = hdr_fix[23:8];
              out_d.hdr_long     = is_long;
              out_d.hdr_ecc_corr = ecc_corr;
              out_d.hdr_ecc_err  = ecc_err;
              out_d.hdr_len_err  = len_err;
              if (!ecc_err) begin
                for (int unsigned i = 0; i < VC_NUM; i++) begin
                  if (hdr_fix[7:6] == 2'(i)) begin
                    if (hdr_fix[5:0] == (MODE ? 6'h01 : 6'h00))      frame_d[i] = 1'b1;
                    else if (hdr_fix[5:0] == (MODE ? 6'h11 : 6'h01)) frame_d[i] = 1'b0;
                  end
                end
              end
              if (ecc_err || len_err) begin
                state_d = StDiscard;
              end else if (!is_long) begin
                state_d = StIdle;
              end else begin
                wc_d     = hdr_fix[23:8];
                cnt_d    = 16'd0;
                crc_d    = 16'hFFFF;
                crc_ph_d = 1'b0;
                state_d  = (hdr_fix[23:8] == 16'd0) ? StCrc : StPld;
              end
            end
          end
          StPld: begin
            out_d.pld_valid = 1'b1;
            out_d.pld_data  = bus.in_data;
            crc_d           = crc_byte(crc_q, bus.in_data);
            cnt_d           = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == wc_q) begin
              out_d.pld_last = 1'b1;
              state_d        = StCrc;
            end
          end
          StCrc: begin
            if (!crc_ph_q) begin
              crc_lo_d = bus.in_data;
              crc_ph_d = 1'b1;
            end else begin
              out_d.crc_valid = 1'b1;
              out_d.crc_err   = {bus.in_data, crc_lo_q} != crc_q;
              state_d         = StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      hcnt_q   <= 2'd0;
      di_q     <= 8'd0;
      wc_lo_q  <= 8'd0;
      wc_hi_q  <= 8'd0;
      crc_lo_q <= 8'd0;
      wc_q     <= 16'd0;
      cnt_q    <= 16'd0;
      crc_q    <= 16'd0;
      crc_ph_q <= 1'b0;
      out_q    <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      di_q     <= di_d;
      wc_lo_q  <= wc_lo_d;
      wc_hi_q  <= wc_hi_d;
      crc_lo_q <= crc_lo_d;
      wc_q     <= wc_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      crc_ph_q <= crc_ph_d;
      out_q    <= out_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.hdr_valid    = out_q.hdr_valid;
  assign bus.hdr_vc       = out_q.hdr_vc;
  assign bus.hdr_dt       = out_q.hdr_dt;
  assign bus.hdr_wc       = out_q.hdr_wc;
  assign bus.hdr_long     = out_q.hdr_long;
  assign bus.hdr_ecc_corr = out_q.hdr_ecc_corr;
  assign bus.hdr_ecc_err  = out_q.hdr_ecc_err;
  assign bus.hdr_len_err  = out_q.hdr_len_err;
  assign bus.pld_valid    = out_q.pld_valid;
  assign bus.pld_data     = out_q.pld_data;
  assign bus.pld_last     = out_q.pld_last;
  assign bus.crc_valid    = out_q.crc_valid;
  assign bus.crc_err      = out_q.crc_err;
  assign bus.err_sync     = out_q.err_sync;
  assign bus.frame_active = frame_q;

endmodule

// File: tb/tb_mipi_pkt_parser.sv
// Directed bench for mipi_pkt_parser: one CSI-2 instance and one DSI instance.
module tb_mipi_pkt_parser;

  logic clk = 1'b0;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mipi_pkt_parser_if #(.VC_NUM(4)) i0 ();
  mipi_pkt_parser_if #(.VC_NUM(4)) i1 ();

  mipi_pkt_parser #(.MODE(1'b0), .VC_NUM(4), .MAX_WC(4096)) dut_csi (
    .clk(clk), .resetn(resetn), .bus(i0)
  );
  mipi_pkt_parser #(.MODE(1'b1), .VC_NUM(4), .MAX_WC(4096)) dut_dsi (
    .clk(clk), .resetn(resetn), .bus(i1)
  );

  // Monitor: collect payload beats and count pulses, sampled on the falling edge.
  logic [7:0] pq0[$], pq1[$], last0[$], last1[$];
  int ncrc0 = 0, ncrc1 = 0, nsync0 = 0, nsync1 = 0;
  logic crcerr0 = 1'b0, crcerr1 = 1'b0;

  always @(negedge clk) begin
    if (i0.pld_valid) begin
      pq0.push_back(i0.pld_data);
      if (i0.pld_last) last0.push_back(i0.pld_data);
    end
    if (i1.pld_valid) begin
      pq1.push_back(i1.pld_data);
      if (i1.pld_last) last1.push_back(i1.pld_data);
    end
    if (i0.crc_valid) begin ncrc0++; crcerr0 = i0.crc_err; end
    if (i1.crc_valid) begin ncrc1++; crcerr1 = i1.crc_err; end
    if (i0.err_sync) nsync0++;
    if (i1.err_sync) nsync1++;
  end

  function automatic logic [5:0] ecc_model(logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Bit-serial CRC-16 reference.
  function automatic logic [15:0] crc_model(logic [15:0] c, logic [7:0] b);
    logic fb;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit m, input logic [7:0] b, input bit sop);
    if (!m) begin i0.in_valid = 1'b1; i0.in_data = b; i0.in_sop = sop; end
    else    begin i1.in_valid = 1'b1; i1.in_data = b; i1.in_sop = sop; end
    @(posedge clk);
    #1;
    i0.in_valid = 1'b0; i0.in_sop = 1'b0;
    i1.in_valid = 1'b0; i1.in_sop = 1'b0;
  endtask

  task automatic send_hdr(input bit m, input logic [7:0] di, input logic [15:0] wc,
                          input logic [23:0] dflip, input logic [7:0] eflip);
    logic [23:0] d;
    logic [7:0]  e;
    d = {wc, di};
    e = {2'b00, ecc_model(d)} ^ eflip;
    d = d ^ dflip;
    send(m, d[7:0], 1'b1);
    send(m, d[15:8], 1'b0);
    send(m, d[23:16], 1'b0);
    send(m, e, 1'b0);
  endtask

  task automatic test_reset;
    logic [45:0] snap;
    snap = {i0.hdr_valid, i0.hdr_vc, i0.hdr_dt, i0.hdr_wc, i0.hdr_long, i0.hdr_ecc_corr,
            i0.hdr_ecc_err, i0.hdr_len_err, i0.pld_valid, i0.pld_data, i0.pld_last,
            i0.crc_valid, i0.crc_err, i0.err_sync, i0.frame_active};
    n_tests++;
    if (snap !== 46'd0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", snap); end
    n_tests++;
    if (i1.frame_active !== 4'b0000 || i1.hdr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_dsi got fa=%b hv=%b exp 0", i1.frame_active, i1.hdr_valid);
    end
  endtask

  task automatic test_frame;
    send_hdr(0, 8'h40, 16'h0001, 24'd0, 8'd0);
    n_tests++;
    if ({i0.hdr_valid, i0.hdr_vc, i0.hdr_dt, i0.hdr_wc, i0.hdr_long} !== {1'b1, 2'd1, 6'h00, 16'h0001, 1'b0}) begin
      n_fail++; $display("FAIL fs_hdr got v=%b vc=%0d dt=%h wc=%h l=%b exp 1 1 00 0001 0",
                         i0.hdr_valid, i0.hdr_vc, i0.hdr_dt, i0.hdr_wc, i0.hdr_long);
    end
    n_tests++;
    if ({i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_len_err} !== 3'b000) begin
      n_fail++; $display("FAIL fs_flags got %b%b%b exp 000", i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_len_err);
    end
    n_tests++;
    if (i0.frame_active !== 4'b0010) begin n_fail++; $display("FAIL fs_active got %b exp 0010", i0.frame_active); end
    send_hdr(0, 8'h41, 16'h0001, 24'd0, 8'd0);
    n_tests++;
    if (i0.frame_active !== 4'b0000) begin n_fail++; $display("FAIL fe_active got %b exp 0000", i0.frame_active); end
  endtask

  task automatic test_long_crc;
    logic [7:0] pay [9];
    int b, lb, c, s;
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    b = pq0.size(); lb = last0.size(); c = ncrc0; s = nsync0;
    send_hdr(0, 8'h2A, 16'd9, 24'd0, 8'd0);
    n_tests++;
    if (i0.hdr_long !== 1'b1) begin n_fail++; $display("FAIL long_class got %b exp 1", i0.hdr_long); end
    foreach (pay[i]) send(0, pay[i], 1'b0);
    send(0, 8'h91, 1'b0);
    send(0, 8'h6F, 1'b0);
    // Back-to-back second packet with a corrupted CRC.
    send_hdr(0, 8'h2A, 16'd9, 24'd0, 8'd0);
    foreach (pay[i]) send(0, pay[i], 1'b0);
    send(0, 8'h90, 1'b0);
    idle(1);
    n_tests++;
    if (ncrc0 !== c + 1 || crcerr0 !== 1'b0) begin
      n_fail++; $display("FAIL crc_good got n=%0d err=%b exp n=%0d err=0", ncrc0, crcerr0, c + 1);
    end
    send(0, 8'h6F, 1'b0);
    idle(2);
    n_tests++;
    if (pq0.size() !== b + 18) begin n_fail++; $display("FAIL pld_count got %0d exp %0d", pq0.size() - b, 18); end
    else begin
      for (int i = 0; i < 18; i++) begin
        n_tests++;
        if (pq0[b + i] !== pay[i % 9]) begin
          n_fail++; $display("FAIL pld_byte%0d got %h exp %h", i, pq0[b + i], pay[i % 9]);
        end
      end
    end
    n_tests++;
    if (last0.size() !== lb + 2 || last0[$] !== 8'h39) begin
      n_fail++; $display("FAIL pld_last got n=%0d exp n=%0d on 39", last0.size() - lb, 2);
    end
    n_tests++;
    if (ncrc0 !== c + 2 || crcerr0 !== 1'b1) begin
      n_fail++; $display("FAIL crc_bad got n=%0d err=%b exp n=%0d err=1", ncrc0, crcerr0, c + 2);
    end
    n_tests++;
    if (nsync0 !== s) begin n_fail++; $display("FAIL b2b_sync got %0d exp %0d", nsync0, s); end
  endtask

  task automatic test_ecc;
    int b, s;
    send_hdr(0, 8'h08, 16'h1234, 24'h000800, 8'd0);
    n_tests++;
    if ({i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_wc, i0.hdr_dt} !== {1'b1, 1'b0, 16'h1234, 6'h08}) begin
      n_fail++; $display("FAIL ecc_data_corr got c=%b e=%b wc=%h dt=%h exp 1 0 1234 08",
                         i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_wc, i0.hdr_dt);
    end
    send_hdr(0, 8'h08, 16'h00AB, 24'd0, 8'h04);
    n_tests++;
    if ({i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_wc} !== {1'b1, 1'b0, 16'h00AB}) begin
      n_fail++; $display("FAIL ecc_par_corr got c=%b e=%b wc=%h exp 1 0 00ab",
                         i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_wc);
    end
    b = pq0.size(); s = nsync0;
    send_hdr(0, 8'h2A, 16'h0005, 24'h000300, 8'd0);
    n_tests++;
    if ({i0.hdr_ecc_corr, i0.hdr_ecc_err} !== 2'b01) begin
      n_fail++; $display("FAIL ecc_double got c=%b e=%b exp 0 1", i0.hdr_ecc_corr, i0.hdr_ecc_err);
    end
    for (int i = 0; i < 5; i++) send(0, 8'(8'hC0 + i), 1'b0);
    idle(2);
    n_tests++;
    if (pq0.size() !== b) begin n_fail++; $display("FAIL ecc_discard got %0d beats exp 0", pq0.size() - b); end
    send_hdr(0, 8'h09, 16'h0042, 24'd0, 8'd0);
    n_tests++;
    if ({i0.hdr_valid, i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_wc} !== {1'b1, 1'b0, 1'b0, 16'h0042}) begin
      n_fail++; $display("FAIL ecc_recover got v=%b c=%b e=%b wc=%h exp 1 0 0 0042",
                         i0.hdr_valid, i0.hdr_ecc_corr, i0.hdr_ecc_err, i0.hdr_wc);
    end
    idle(1);
    n_tests++;
    if (nsync0 !== s) begin n_fail++; $display("FAIL ecc_sync got %0d exp %0d", nsync0, s); end
  endtask

  task automatic test_dsi;
    logic [7:0]  pay [4];
    logic [15:0] crc;
    int b, lb, c;
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    c = ncrc1;
    send_hdr(1, 8'h39, 16'h0000, 24'd0, 8'd0);
    n_tests++;
    if (i1.hdr_long !== 1'b1) begin n_fail++; $display("FAIL dsi_long got %b exp 1", i1.hdr_long); end
    send(1, 8'hFF, 1'b0);
    send(1, 8'hFF, 1'b0);
    idle(1);
    n_tests++;
    if (ncrc1 !== c + 1 || crcerr1 !== 1'b0) begin
      n_fail++; $display("FAIL dsi_wc0_crc got n=%0d err=%b exp n=%0d err=0", ncrc1, crcerr1, c + 1);
    end
    send_hdr(1, 8'h15, 16'h0203, 24'd0, 8'd0);
    n_tests++;
    if (i1.hdr_long !== 1'b0 || i1.hdr_wc !== 16'h0203) begin
      n_fail++; $display("FAIL dsi_short got l=%b wc=%h exp 0 0203", i1.hdr_long, i1.hdr_wc);
    end
    b = pq1.size(); lb = last1.size();
    crc = 16'hFFFF;
    send_hdr(1, 8'h39, 16'd4, 24'd0, 8'd0);
    foreach (pay[i]) begin
      send(1, pay[i], 1'b0);
      crc = crc_model(crc, pay[i]);
      idle(3);
    end
    send(1, crc[7:0], 1'b0);
    idle(3);
    send(1, crc[15:8], 1'b0);
    idle(2);
    n_tests++;
    if (pq1.size() !== b + 4) begin n_fail++; $display("FAIL gap_count got %0d exp 4", pq1.size() - b); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (pq1[b + i] !== pay[i]) begin n_fail++; $display("FAIL gap_byte%0d got %h exp %h", i, pq1[b + i], pay[i]); end
      end
    end
    n_tests++;
    if (last1.size() !== lb + 1 || last1[$] !== 8'hD4) begin
      n_fail++; $display("FAIL gap_last got n=%0d exp 1 on d4", last1.size() - lb);
    end
    n_tests++;
    if (ncrc1 !== c + 2 || crcerr1 !== 1'b0) begin
      n_fail++; $display("FAIL gap_crc got n=%0d err=%b exp n=%0d err=0", ncrc1, crcerr1, c + 2);
    end
  endtask

  task automatic test_sop_abort;
    int b, lb, c, s;
    b = pq0.size(); lb = last0.size(); c = ncrc0; s = nsync0;
    send_hdr(0, 8'h2A, 16'd16, 24'd0, 8'd0);
    for (int i = 0; i < 4; i++) send(0, 8'(8'h50 + i), 1'b0);
    send_hdr(0, 8'h08, 16'h0055, 24'd0, 8'd0);
    n_tests++;
    if (i0.hdr_valid !== 1'b1 || i0.hdr_wc !== 16'h0055) begin
      n_fail++; $display("FAIL abort_hdr got v=%b wc=%h exp 1 0055", i0.hdr_valid, i0.hdr_wc);
    end
    idle(2);
    n_tests++;
    if (nsync0 !== s + 1) begin n_fail++; $display("FAIL abort_sync got %0d exp %0d", nsync0, s + 1); end
    n_tests++;
    if (pq0.size() !== b + 4 || last0.size() !== lb || ncrc0 !== c) begin
      n_fail++; $display("FAIL abort_pld got beats=%0d last=%0d crc=%0d exp 4 0 0",
                         pq0.size() - b, last0.size() - lb, ncrc0 - c);
    end
  endtask

  task automatic test_len_err;
    int b;
    b = pq0.size();
    send_hdr(0, 8'h2A, 16'd5000, 24'd0, 8'd0);
    n_tests++;
    if ({i0.hdr_len_err, i0.hdr_ecc_err, i0.hdr_long} !== 3'b101) begin
      n_fail++; $display("FAIL len_err got le=%b ee=%b l=%b exp 1 0 1", i0.hdr_len_err, i0.hdr_ecc_err, i0.hdr_long);
    end
    for (int i = 0; i < 6; i++) send(0, 8'(8'h70 + i), 1'b0);
    idle(2);
    n_tests++;
    if (pq0.size() !== b) begin n_fail++; $display("FAIL len_discard got %0d beats exp 0", pq0.size() - b); end
    send_hdr(0, 8'h08, 16'h0077, 24'd0, 8'd0);
    n_tests++;
    if (i0.hdr_len_err !== 1'b0 || i0.hdr_wc !== 16'h0077) begin
      n_fail++; $display("FAIL len_recover got le=%b wc=%h exp 0 0077", i0.hdr_len_err, i0.hdr_wc);
    end
  endtask

  task automatic test_reset_mid;
    logic [45:0] snap;
    logic [15:0] crc;
    int b, c;
    send_hdr(0, 8'h80, 16'h0000, 24'd0, 8'd0);
    n_tests++;
    if (i0.frame_active !== 4'b0100) begin n_fail++; $display("FAIL rst_fs got %b exp 0100", i0.frame_active); end
    send_hdr(0, 8'h2A, 16'd8, 24'd0, 8'd0);
    for (int i = 0; i < 3; i++) send(0, 8'(8'h60 + i), 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    snap = {i0.hdr_valid, i0.hdr_vc, i0.hdr_dt, i0.hdr_wc, i0.hdr_long, i0.hdr_ecc_corr,
            i0.hdr_ecc_err, i0.hdr_len_err, i0.pld_valid, i0.pld_data, i0.pld_last,
            i0.crc_valid, i0.crc_err, i0.err_sync, i0.frame_active};
    n_tests++;
    if (snap !== 46'd0) begin n_fail++; $display("FAIL rst_mid got %h exp 0", snap); end
    resetn = 1'b1;
    idle(1);
    b = pq0.size(); c = ncrc0;
    crc = crc_model(crc_model(16'hFFFF, 8'h11), 8'h22);
    send_hdr(0, 8'h2A, 16'd2, 24'd0, 8'd0);
    n_tests++;
    if (i0.hdr_valid !== 1'b1 || i0.hdr_wc !== 16'd2) begin
      n_fail++; $display("FAIL rst_hdr got v=%b wc=%h exp 1 0002", i0.hdr_valid, i0.hdr_wc);
    end
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, crc[7:0], 1'b0);
    send(0, crc[15:8], 1'b0);
    idle(2);
    n_tests++;
    if (pq0.size() !== b + 2 || pq0[$] !== 8'h22 || ncrc0 !== c + 1 || crcerr0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_fresh got beats=%0d crc=%0d err=%b exp 2 1 0",
                         pq0.size() - b, ncrc0 - c, crcerr0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    i0.in_valid = 1'b0; i0.in_data = 8'd0; i0.in_sop = 1'b0;
    i1.in_valid = 1'b0; i1.in_data = 8'd0; i1.in_sop = 1'b0;
    idle(3);
    test_reset;
    resetn = 1'b1;
    idle(1);
    test_frame;
    test_long_crc;
    test_ecc;
    test_dsi;
    test_sop_abort;
    test_len_err;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
